// File: rtl/vt52_escape_handler.sv
// VT52 command interpreter: turns a received byte stream into character-buffer
// writes, cursor updates and scroll requests, including the erase sequences.
module vt52_escape_handler #(
   parameter int COLS     = 64,
   parameter int ROWS     = 16,
   parameter int COL_BITS = 6,
   parameter int ROW_BITS = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [7:0]          data,
   input  logic                valid,
   output logic                ready,
   output logic [7:0]          new_char,
   output logic [COL_BITS-1:0] new_char_x,
   output logic [ROW_BITS-1:0] new_char_y,
   output logic                new_char_wen,
   output logic [COL_BITS-1:0] new_cursor_x,
   output logic [ROW_BITS-1:0] new_cursor_y,
   output logic                new_cursor_wen,
   output logic                scroll
);

   typedef enum logic [2:0] {
      NORMAL,
      ESC,
      Y_ROW,
      Y_COL,
      CLEAR
   } state_t;

   localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(COLS - 1);
   localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(ROWS - 1);
   localparam logic [8:0]          COLS9 = 9'(COLS);
   localparam logic [8:0]          ROWS9 = 9'(ROWS);

   state_t              state_reg;
   logic [COL_BITS-1:0] cur_x_reg;
   logic [ROW_BITS-1:0] cur_y_reg;
   logic [ROW_BITS-1:0] row_hold_reg;
   logic [COL_BITS-1:0] clear_x_reg;
   logic [ROW_BITS-1:0] clear_y_reg;
   logic [ROW_BITS-1:0] end_y_reg;
   logic [7:0]          char_reg;
   logic [COL_BITS-1:0] char_x_reg;
   logic [ROW_BITS-1:0] char_y_reg;
   logic                char_wen_reg;
   logic                cursor_wen_reg;
   logic                scroll_reg;

   logic                accept;
   logic [COL_BITS-1:0] clear_x_next;
   logic [ROW_BITS-1:0] clear_y_next;
   logic                clear_last;
   logic [7:0]          coord_off;
   logic [ROW_BITS-1:0] y_row_val;
   logic [COL_BITS-1:0] y_col_val;

   assign ready  = (state_reg != CLEAR) && !clr;
   assign accept = valid && ready;

   // Erase walks row-major; the end column is always the last column.
   always_comb begin
      clear_x_next = clear_x_reg + COL_BITS'(1);
      clear_y_next = clear_y_reg;
      if (clear_x_reg == X_MAX) begin
         clear_x_next = '0;
         clear_y_next = clear_y_reg + ROW_BITS'(1);
      end
   end

   assign clear_last = (clear_x_reg == X_MAX) && (clear_y_reg == end_y_reg);

   // Direct-cursor-address coordinates: subtract the 0x20 bias in 8 bits, then clamp.
   always_comb begin
      coord_off = data - 8'h20;
      y_row_val = '0;
      y_col_val = '0;
      if (data >= 8'h20) begin
         if ({1'b0, coord_off} >= ROWS9)
            y_row_val = Y_MAX;
         else
            y_row_val = coord_off[ROW_BITS-1:0];
         if ({1'b0, coord_off} >= COLS9)
            y_col_val = X_MAX;
         else
            y_col_val = coord_off[COL_BITS-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg      <= NORMAL;
         cur_x_reg      <= '0;
         cur_y_reg      <= '0;
         row_hold_reg   <= '0;
         clear_x_reg    <= '0;
         clear_y_reg    <= '0;
         end_y_reg      <= '0;
         char_reg       <= '0;
         char_x_reg     <= '0;
         char_y_reg     <= '0;
         char_wen_reg   <= 1'b0;
         cursor_wen_reg <= 1'b0;
         scroll_reg     <= 1'b0;
      end else begin
         char_wen_reg   <= 1'b0;
         cursor_wen_reg <= 1'b0;
         scroll_reg     <= 1'b0;
         case (state_reg)
            NORMAL: begin
               if (accept) begin
                  if (data >= 8'h20 && data <= 8'h7E) begin
                     char_reg       <= data;
                     char_x_reg     <= cur_x_reg;
                     char_y_reg     <= cur_y_reg;
                     char_wen_reg   <= 1'b1;
                     cursor_wen_reg <= 1'b1;
                     if (cur_x_reg != X_MAX)
                        cur_x_reg <= cur_x_reg + COL_BITS'(1);
                  end else begin
                     case (data)
                        8'h0D: begin
                           cur_x_reg      <= '0;
                           cursor_wen_reg <= 1'b1;
                        end
                        8'h0A: begin
                           cursor_wen_reg <= 1'b1;
                           if (cur_y_reg == Y_MAX)
                              scroll_reg <= 1'b1;
                           else
                              cur_y_reg <= cur_y_reg + ROW_BITS'(1);
                        end
                        8'h08: begin
                           cursor_wen_reg <= 1'b1;
                           if (cur_x_reg != '0)
                              cur_x_reg <= cur_x_reg - COL_BITS'(1);
                        end
                        8'h1B:   state_reg <= ESC;
                        default: state_reg <= NORMAL;
                     endcase
                  end
               end
            end

            ESC: begin
               if (accept) begin
                  state_reg <= NORMAL;
                  case (data)
                     8'h41: begin
                        cursor_wen_reg <= 1'b1;
                        if (cur_y_reg != '0)
                           cur_y_reg <= cur_y_reg - ROW_BITS'(1);
                     end
                     8'h42: begin
                        cursor_wen_reg <= 1'b1;
                        if (cur_y_reg != Y_MAX)
                           cur_y_reg <= cur_y_reg + ROW_BITS'(1);
                     end
                     8'h43: begin
                        cursor_wen_reg <= 1'b1;
                        if (cur_x_reg != X_MAX)
                           cur_x_reg <= cur_x_reg + COL_BITS'(1);
                     end
                     8'h44: begin
                        cursor_wen_reg <= 1'b1;
                        if (cur_x_reg != '0)
                           cur_x_reg <= cur_x_reg - COL_BITS'(1);
                     end
                     8'h48: begin
                        cursor_wen_reg <= 1'b1;
                        cur_x_reg      <= '0;
                        cur_y_reg      <= '0;
                     end
                     8'h59: state_reg <= Y_ROW;
                     8'h4B, 8'h4A: begin
                        // The first blank is written on the accepting edge itself.
                        state_reg    <= CLEAR;
                        clear_x_reg  <= cur_x_reg;
                        clear_y_reg  <= cur_y_reg;
                        end_y_reg    <= (data == 8'h4B) ? cur_y_reg : Y_MAX;
                        char_reg     <= 8'h20;
                        char_x_reg   <= cur_x_reg;
                        char_y_reg   <= cur_y_reg;
                        char_wen_reg <= 1'b1;
                     end
                     default: state_reg <= NORMAL;
                  endcase
               end
            end

            Y_ROW: begin
               if (accept) begin
                  row_hold_reg <= y_row_val;
                  state_reg    <= Y_COL;
               end
            end

            Y_COL: begin
               if (accept) begin
                  cur_x_reg      <= y_col_val;
                  cur_y_reg      <= row_hold_reg;
                  cursor_wen_reg <= 1'b1;
                  state_reg      <= NORMAL;
               end
            end

            CLEAR: begin
               if (clear_last) begin
                  state_reg <= NORMAL;
               end else begin
                  clear_x_reg  <= clear_x_next;
                  clear_y_reg  <= clear_y_next;
                  char_reg     <= 8'h20;
                  char_x_reg   <= clear_x_next;
                  char_y_reg   <= clear_y_next;
                  char_wen_reg <= 1'b1;
               end
            end

            default: state_reg <= NORMAL;
         endcase
      end
   end

   assign new_char       = char_reg;
   assign new_char_x     = char_x_reg;
   assign new_char_y     = char_y_reg;
   assign new_char_wen   = char_wen_reg;
   assign new_cursor_x   = cur_x_reg;
   assign new_cursor_y   = cur_y_reg;
   assign new_cursor_wen = cursor_wen_reg;
   assign scroll         = scroll_reg;

endmodule

// File: tb/tb_vt52_escape_handler.sv
// Bench for vt52_escape_handler: directed test-plan sequences followed by random
// byte traffic, all compared each cycle against a screen-level reference model.
module tb_vt52_escape_handler;
   localparam int COLS = 64;
   localparam int ROWS = 16;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic [7:0] new_char;
   logic [5:0] new_char_x;
   logic [3:0] new_char_y;
   logic       new_char_wen;
   logic [5:0] new_cursor_x;
   logic [3:0] new_cursor_y;
   logic       new_cursor_wen;
   logic       scroll;

   always #5 clk = ~clk;

   vt52_escape_handler #(.COLS(COLS), .ROWS(ROWS), .COL_BITS(6), .ROW_BITS(4)) dut (
      .clk(clk), .clr(clr), .data(data), .valid(valid), .ready(ready),
      .new_char(new_char), .new_char_x(new_char_x), .new_char_y(new_char_y),
      .new_char_wen(new_char_wen), .new_cursor_x(new_cursor_x),
      .new_cursor_y(new_cursor_y), .new_cursor_wen(new_cursor_wen), .scroll(scroll)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: cursor, escape-sequence progress and a queue of pending erase cells.
   int  mcx, mcy, mode, row_hold;
   int  pend[$];
   bit  busy, acc, en, rst_seen;
   bit  e_wen, e_cwen, e_sc;
   int  e_ch, e_x, e_y;

   function automatic int coord(input int b, input int lim);
      if (b < 32) return 0;
      if (b - 32 >= lim) return lim - 1;
      return b - 32;
   endfunction

   task automatic put_cell(input int idx);
      e_wen = 1; e_ch = 32; e_x = idx % COLS; e_y = idx / COLS;
   endtask

   always @(posedge clk) begin
      en = 1;
      e_wen = 0; e_cwen = 0; e_sc = 0;
      if (clr) begin
         mcx = 0; mcy = 0; mode = 0; row_hold = 0;
         pend.delete();
         busy = 0; acc = 0; rst_seen = 1;
         e_ch = 0; e_x = 0; e_y = 0;
      end else begin
         rst_seen = 0;
         acc = valid && !busy;
         busy = 0;
         if (pend.size() > 0) begin
            put_cell(pend.pop_front());
            busy = 1;
         end else if (acc) begin
            int b;
            b = int'(data);
            case (mode)
               0: begin
                  if (b >= 32 && b <= 126) begin
                     e_wen = 1; e_ch = b; e_x = mcx; e_y = mcy;
                     if (mcx < COLS - 1) mcx++;
                     e_cwen = 1;
                  end else if (b == 13) begin
                     mcx = 0; e_cwen = 1;
                  end else if (b == 10) begin
                     if (mcy == ROWS - 1) e_sc = 1; else mcy++;
                     e_cwen = 1;
                  end else if (b == 8) begin
                     if (mcx > 0) mcx--;
                     e_cwen = 1;
                  end else if (b == 27) begin
                     mode = 1;
                  end
               end
               1: begin
                  mode = 0;
                  case (b)
                     65: begin if (mcy > 0) mcy--; e_cwen = 1; end
                     66: begin if (mcy < ROWS - 1) mcy++; e_cwen = 1; end
                     67: begin if (mcx < COLS - 1) mcx++; e_cwen = 1; end
                     68: begin if (mcx > 0) mcx--; e_cwen = 1; end
                     72: begin mcx = 0; mcy = 0; e_cwen = 1; end
                     89: mode = 2;
                     75, 74: begin
                        int last;
                        last = (b == 75) ? mcy * COLS + COLS - 1 : ROWS * COLS - 1;
                        for (int i = mcy * COLS + mcx; i <= last; i++) pend.push_back(i);
                        put_cell(pend.pop_front());
                        busy = 1;
                     end
                     default: ;
                  endcase
               end
               2: begin row_hold = coord(b, ROWS); mode = 3; end
               default: begin
                  mcx = coord(b, COLS); mcy = row_hold; e_cwen = 1; mode = 0;
               end
            endcase
         end
      end
   end

   // Observed-output tallies used by the directed checks.
   int wr_cnt = 0, cw_cnt = 0, sc_cnt = 0, rdy_low_cnt = 0;
   int last_ch = 0, last_x = 0, last_y = 0;

   always @(negedge clk) begin
      if (en) begin
         chk("char_wen", new_char_wen, e_wen);
         chk("cursor_wen", new_cursor_wen, e_cwen);
         chk("scroll", scroll, e_sc);
         chk("cursor_x", new_cursor_x, mcx);
         chk("cursor_y", new_cursor_y, mcy);
         chk("ready", ready, !busy && !clr);
         if (e_wen || rst_seen) begin
            chk("char", new_char, e_ch);
            chk("char_x", new_char_x, e_x);
            chk("char_y", new_char_y, e_y);
         end
      end
      if (new_char_wen === 1'b1) begin
         wr_cnt++; last_ch = new_char; last_x = new_char_x; last_y = new_char_y;
      end
      if (new_cursor_wen === 1'b1) cw_cnt++;
      if (scroll === 1'b1) sc_cnt++;
      if (ready === 1'b0 && !clr) rdy_low_cnt++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      valid = 1'b1; data = b;
      tick();
      while (!acc && n < 2000) begin tick(); n++; end
      valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: byte %02h not accepted, expected acceptance", b);
      end else
         $display("send %02h accepted, cursor model (%0d,%0d)", b, mcx, mcy);
   endtask

   task automatic go_to(input int x, input int y);
      send(8'h1B); send(8'h59); send(8'(32 + y)); send(8'(32 + x));
   endtask

   string cmd_chars = "ABCDHYKJ";

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 15))
         0, 1, 2, 3, 4, 5: return 8'($urandom_range(32, 126));
         6:  return 8'h0D;
         7:  return 8'h0A;
         8:  return 8'h08;
         9:  return 8'h1B;
         10, 11, 12: return 8'(cmd_chars[$urandom_range(0, 7)]);
         13: return 8'($urandom_range(0, 255));
         14: return 8'($urandom_range(0, 0) + 32 + $urandom_range(0, 80));
         default: return 8'h7F;
      endcase
   endfunction

   initial begin
      int w0, w1, c0, s0, r0, n;
      clr = 1'b1;
      settle(2);
      chk("rst_ready", ready, 0);
      chk("rst_wen", new_char_wen, 0);
      chk("rst_char", new_char, 0);
      chk("rst_cursor_x", new_cursor_x, 0);
      chk("rst_cursor_y", new_cursor_y, 0);
      clr = 1'b0;
      settle(1);
      chk("ready_after_rst", ready, 1);

      // "AB" from home
      w0 = wr_cnt; c0 = cw_cnt;
      send(8'h41); send(8'h42);
      settle(2);
      chk("ab_writes", wr_cnt - w0, 2);
      chk("ab_cursor_wen", cw_cnt - c0, 2);
      chk("ab_last_char", last_ch, 8'h42);
      chk("ab_last_x", last_x, 1);
      chk("ab_cursor_x", new_cursor_x, 2);
      chk("ab_model_x", mcx, 2);

      // Right-edge saturation (column byte 0x7F clamps to 63)
      go_to(95, 0);
      w0 = wr_cnt;
      send(8'h58); send(8'h59);
      settle(2);
      chk("edge_writes", wr_cnt - w0, 2);
      chk("edge_last_x", last_x, 63);
      chk("edge_cursor_x", new_cursor_x, 63);

      // LF on bottom row scrolls, then CR
      go_to(5, 15);
      s0 = sc_cnt;
      send(8'h0A);
      settle(2);
      chk("lf_scroll", sc_cnt - s0, 1);
      chk("lf_cursor_y", new_cursor_y, 15);
      chk("lf_cursor_x", new_cursor_x, 5);
      send(8'h0D);
      settle(2);
      chk("cr_cursor_x", new_cursor_x, 0);
      chk("cr_cursor_y", new_cursor_y, 15);

      // Direct cursor address
      send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
      settle(2);
      chk("esc_y_x", new_cursor_x, 10);
      chk("esc_y_y", new_cursor_y, 5);
      send(8'h1B); send(8'h59); send(8'h7F); send(8'h7F);
      settle(2);
      chk("esc_y_clamp_x", new_cursor_x, 63);
      chk("esc_y_clamp_y", new_cursor_y, 15);

      // Erase to end of line from (60,3)
      go_to(60, 3);
      settle(1);
      w0 = wr_cnt; r0 = rdy_low_cnt;
      send(8'h1B); send(8'h4B);
      settle(8);
      chk("k_writes", wr_cnt - w0, 4);
      chk("k_ready_low", rdy_low_cnt - r0, 4);
      chk("k_last_x", last_x, 63);
      chk("k_last_y", last_y, 3);
      chk("k_last_char", last_ch, 8'h20);
      chk("k_cursor_x", new_cursor_x, 60);
      chk("k_model_x", mcx, 60);

      // Erase to end of screen from (62,14)
      go_to(62, 14);
      settle(1);
      w0 = wr_cnt;
      send(8'h1B); send(8'h4A);
      settle(72);
      chk("j_writes", wr_cnt - w0, 66);
      chk("j_last_x", last_x, 63);
      chk("j_last_y", last_y, 15);
      chk("j_cursor_y", new_cursor_y, 14);

      // Same erase aborted by clr after ten writes
      go_to(62, 14);
      settle(1);
      w0 = wr_cnt;
      send(8'h1B); send(8'h4A);
      n = 0;
      while (wr_cnt - w0 < 10 && n < 200) begin tick(); n++; end
      chk("abort_reached_10", (wr_cnt - w0 >= 10) ? 1 : 0, 1);
      clr = 1'b1;
      settle(1);
      chk("abort_wen", new_char_wen, 0);
      chk("abort_char", new_char, 0);
      chk("abort_char_x", new_char_x, 0);
      chk("abort_cursor_x", new_cursor_x, 0);
      chk("abort_cursor_y", new_cursor_y, 0);
      chk("abort_ready_in_clr", ready, 0);
      w1 = wr_cnt;
      clr = 1'b0;
      settle(1);
      chk("abort_ready_back", ready, 1);
      settle(5);
      chk("abort_write_total", w1 - w0, 11);
      chk("abort_no_more", wr_cnt, w1);

      // Random traffic, every cycle checked against the model
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #1;
         clr   = ($urandom_range(0, 799) == 0);
         valid = ($urandom_range(0, 9) < 7);
         data  = pick_byte();
      end
      @(posedge clk); #1;
      clr = 1'b0; valid = 1'b0;
      settle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vt52_escape_handler.md
Name: vt52_escape_handler

Overview:
- Parametrised successor to the stub terminal command path.
- Consumes the received byte stream over a valid/ready handshake and interprets printable characters, C0 controls and VT52 escape sequences.
- Produces character-buffer writes (with explicit address), cursor updates and a scroll request.
- Sits between the UART receiver and the character buffer / cursor registers, in the single system clock domain.

Parameters:
- COLS, 64, number of screen columns.
- ROWS, 16, number of screen rows.
- COL_BITS, 6, width of column values; must satisfy 2^COL_BITS >= COLS.
- ROW_BITS, 4, width of row values; must satisfy 2^ROW_BITS >= ROWS.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- data  in  8  received byte.
- valid  in  1  data is valid.
- ready  out  1  handler can accept a byte; a byte transfers when valid && ready at a rising edge.
- new_char  out  8  character to write.
- new_char_x  out  COL_BITS  write column.
- new_char_y  out  ROW_BITS  write row.
- new_char_wen  out  1  one-cycle write strobe.
- new_cursor_x  out  COL_BITS  cursor column.
- new_cursor_y  out  ROW_BITS  cursor row.
- new_cursor_wen  out  1  one-cycle cursor update strobe.
- scroll  out  1  one-cycle request to scroll the screen up one line.

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high.
- Reset: state NORMAL; cursor = (0,0); all strobes 0; new_char, new_char_x, new_char_y = 0. ready = 0 while clr is high.
- clr during CLEAR aborts the clear immediately; no further writes occur.
- ready is combinational: (state != CLEAR) && !clr.
- Latency: all outputs are registered and respond in the cycle after the accepting edge (1-cycle latency).
- Strobes not described below stay 0.
- States: NORMAL, ESC, Y_ROW, Y_COL, CLEAR.
- NORMAL, printable byte 0x20..0x7E:
  - new_char = byte, (new_char_x, new_char_y) = cursor before the update, new_char_wen = 1.
  - Cursor x += 1, saturating at COLS-1 (no autowrap); new_cursor_wen = 1.
- NORMAL, controls:
  - 0x0D CR: x = 0.
  - 0x0A LF: y += 1. If y == ROWS-1, y is unchanged and scroll = 1.
  - 0x08 BS: x -= 1, saturating at 0.
  - Each of CR, LF and BS pulses new_cursor_wen, even if the cursor value is unchanged.
  - 0x1B ESC: go to ESC, no outputs.
  - All other bytes (other controls, 0x7F, 0x80..0xFF): ignored.
- ESC, next byte:
  - 'A' up, 'B' down, 'C' right, 'D' left: 1-step moves saturating at the screen edges, with no scroll; pulse new_cursor_wen.
  - 'H': home to (0,0); pulse new_cursor_wen.
  - 'Y': go to Y_ROW.
  - 'K': go to CLEAR with end = (COLS-1, y).
  - 'J': go to CLEAR with end = (COLS-1, ROWS-1).
  - Any other byte, including ESC: ignored, back to NORMAL.
  - After A–D and H, the state returns to NORMAL.
- Y_ROW: row = byte - 0x20. Bytes < 0x20 map to 0; results >= ROWS clamp to ROWS-1. Held internally; go to Y_COL.
- Y_COL: col = byte - 0x20, same clamping against COLS. Cursor = (col,row); pulse new_cursor_wen; go to NORMAL.
- CLEAR:
  - Writes 0x20 one cell per cycle, row-major, from the cursor position to end inclusive. new_char_wen = 1 every cycle.
  - After x = COLS-1 the next cell is x = 0, y + 1.
  - The cursor is not moved and new_cursor_wen stays 0.
  - Entering: the first write appears in the cycle after the accepting edge. The cell count is (end linear index - start linear index + 1).
  - After the last write, state = NORMAL; ready is high in the cycle following the last write.
  - valid is ignored while ready = 0; the upstream block holds data.
- Width rules:
  - Cursor arithmetic uses COL_BITS/ROW_BITS with explicit saturation; no modular wrap.
  - Y-sequence subtraction is done in 8 bits before clamping.

Test Plan:
- Reset, then send "AB" -> writes ('A',0,0) and ('B',1,0) on consecutive accept+1 cycles; cursor ends at (2,0); new_cursor_wen pulses twice.
- Cursor at (63,0), send 'X','Y' -> both written at x=63; cursor stays at 63.
- Cursor at (5,15), send LF -> scroll pulses once; cursor (5,15). Then send CR -> cursor (0,15).
- Send ESC 'Y' 0x25 0x2A -> cursor (10,5). Send ESC 'Y' 0x7F 0x7F -> cursor (63,15).
- Cursor at (60,3), send ESC 'K' -> exactly 4 writes of 0x20 at x=60..63, y=3; ready low for 4 cycles; cursor unchanged.
- Cursor at (62,14), send ESC 'J' -> 66 writes ending at (63,15). Assert clr after 10 writes -> no further writes; outputs zero; cursor (0,0); ready returns the cycle after clr drops.
